// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the 8N1 UART receiver: first-word fall-through
// storage that drops framing-error bytes and keeps overflow/error statistics.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_error,
  output logic                  in_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_en,
  input  logic                  clear,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            err_count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned IDX_W = DEPTH_LOG2;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             err_seen;
  logic             drop_good;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);

  // Handshake decisions look only at pre-edge state, so in_ready has no input path.
  assign push      = in_valid && !in_error && !full;
  assign pop       = rd_en && !empty;
  assign err_seen  = in_valid && in_error;
  assign drop_good = in_valid && !in_error && full;

  assign in_ready = !full;
  assign rd_valid = !empty;
  assign rd_data  = empty ? 8'h00 : mem[rd_idx];
  assign count    = wr_ptr - rd_ptr;

  // Storage array is intentionally not reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Diagnostics: sticky overflow and saturating framing-error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      err_count <= 8'h00;
    end else if (clear) begin
      overflow  <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (drop_good) overflow <= 1'b1;
      if (err_seen && (err_count != 8'hff)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at the default depth of 16.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_error;
  logic       in_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_en;
  logic       clear;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_error  (in_error),
    .in_ready  (in_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_en     (rd_en),
    .clear     (clear),
    .count     (count),
    .overflow  (overflow),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then return idle inputs 1 time unit after the edge.
  task automatic step(input logic v, input logic e, input logic [7:0] d,
                      input logic r, input logic c);
    in_valid = v;
    in_error = e;
    in_data  = d;
    rd_en    = r;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_error = 1'b0;
    in_data  = 8'h00;
    rd_en    = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_error = 1'b0;
    rd_en = 1'b0; clear = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'h00);
    check("rst_count",     32'(count),     32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic push then pop of three bytes
    step(1, 0, 8'h56, 0, 0);
    check("b_cnt1", 32'(count), 32'd1);
    check("b_val1", 32'(rd_valid), 32'd1);
    check("b_dat1", 32'(rd_data), 32'h56);
    step(1, 0, 8'h77, 0, 0);
    check("b_cnt2", 32'(count), 32'd2);
    step(1, 0, 8'hab, 0, 0);
    check("b_cnt3", 32'(count), 32'd3);
    check("b_head", 32'(rd_data), 32'h56);
    step(0, 0, 8'h00, 1, 0);
    check("b_pop1_dat", 32'(rd_data), 32'h77);
    check("b_pop1_cnt", 32'(count), 32'd2);
    step(0, 0, 8'h00, 1, 0);
    check("b_pop2_dat", 32'(rd_data), 32'hab);
    check("b_pop2_cnt", 32'(count), 32'd1);
    step(0, 0, 8'h00, 1, 0);
    check("b_pop3_cnt", 32'(count), 32'd0);
    check("b_pop3_val", 32'(rd_valid), 32'd0);
    check("b_pop3_dat", 32'(rd_data), 32'h00);
    step(0, 0, 8'h00, 1, 0);
    check("b_empty_pop_cnt", 32'(count), 32'd0);

    // Fill to 16, then overflow
    for (int i = 0; i < 16; i++) begin
      check("f_ready", 32'(in_ready), 32'd1);
      step(1, 0, 8'(i), 0, 0);
    end
    check("f_cnt16", 32'(count), 32'd16);
    check("f_not_ready", 32'(in_ready), 32'd0);
    check("f_ovf0", 32'(overflow), 32'd0);
    step(1, 0, 8'hff, 0, 0);
    check("f_ovf1", 32'(overflow), 32'd1);
    check("f_cnt_after_drop", 32'(count), 32'd16);

    // Push offered together with a pop while full: push refused
    check("f_head00", 32'(rd_data), 32'h00);
    step(1, 0, 8'hca, 1, 0);
    check("pp_cnt15", 32'(count), 32'd15);
    check("pp_ovf", 32'(overflow), 32'd1);
    check("pp_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 16; i++) begin
      check("f_drain_dat", 32'(rd_data), 32'(i));
      step(0, 0, 8'h00, 1, 0);
    end
    check("f_drain_cnt", 32'(count), 32'd0);
    check("f_drain_val", 32'(rd_valid), 32'd0);

    // Clear with overflow=1 and count=5, colliding with push/pop/error-free traffic
    for (int i = 0; i < 5; i++) step(1, 0, 8'h30 + 8'(i), 0, 0);
    check("c_cnt5", 32'(count), 32'd5);
    check("c_ovf_pre", 32'(overflow), 32'd1);
    step(1, 0, 8'h99, 1, 1);
    check("c_cnt", 32'(count), 32'd0);
    check("c_ovf", 32'(overflow), 32'd0);
    check("c_err", 32'(err_count), 32'd0);
    check("c_val", 32'(rd_valid), 32'd0);

    // Framing-error bytes interleaved with good bytes
    step(1, 1, 8'h11, 0, 0);
    check("e_err1", 32'(err_count), 32'd1);
    check("e_cnt0", 32'(count), 32'd0);
    step(1, 0, 8'h55, 0, 0);
    step(1, 1, 8'h22, 0, 0);
    step(1, 0, 8'h66, 0, 0);
    step(1, 1, 8'h33, 0, 0);
    check("e_err3", 32'(err_count), 32'd3);
    check("e_cnt2", 32'(count), 32'd2);
    check("e_ovf", 32'(overflow), 32'd0);
    check("e_head55", 32'(rd_data), 32'h55);
    step(0, 0, 8'h00, 1, 0);
    check("e_next66", 32'(rd_data), 32'h66);
    step(0, 0, 8'h00, 1, 0);
    check("e_empty", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 8'(i), 0, 0);
      if (i == 251) check("e_err255", 32'(err_count), 32'd255);
    end
    check("e_sat", 32'(err_count), 32'd255);
    check("e_sat_cnt", 32'(count), 32'd0);

    // Streaming: one push and one pop per clock for 40 bytes
    step(1, 0, 8'h80, 0, 0);
    check("s_cnt1", 32'(count), 32'd1);
    for (int i = 1; i < 40; i++) begin
      check("s_dat", 32'(rd_data), 32'(8'h80 + 8'(i - 1)));
      step(1, 0, 8'h80 + 8'(i), 1, 0);
      check("s_cnt", 32'(count), 32'd1);
    end
    check("s_last", 32'(rd_data), 32'ha7);
    step(0, 0, 8'h00, 1, 0);
    check("s_empty", 32'(rd_valid), 32'd0);

    // Asynchronous reset mid-stream, between clock edges
    step(1, 0, 8'h41, 0, 0);
    step(1, 0, 8'h42, 0, 0);
    step(1, 0, 8'hee, 0, 0);
    check("r_cnt3", 32'(count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("r_cnt", 32'(count), 32'd0);
    check("r_val", 32'(rd_valid), 32'd0);
    check("r_dat", 32'(rd_data), 32'h00);
    check("r_rdy", 32'(in_ready), 32'd1);
    check("r_err", 32'(err_count), 32'd0);
    check("r_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 8'h5a, 0, 0);
    check("r_post_dat", 32'(rd_data), 32'h5a);
    check("r_post_cnt", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
